// File: rtl/note_pkg.sv
// Shared definitions for the tone meter and the tone generator: count width,
// default timing/tolerance values and the meter state encoding.
package note_pkg;

    localparam int unsigned CntWidth = 32;

    localparam logic [CntWidth-1:0] DefTimeout = 32'd50_000_000;
    localparam logic [CntWidth-1:0] DefTol     = 32'd2;
    localparam logic [CntWidth-1:0] DefMinHalf = 32'd2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitEdge,
        StFirst,
        StMatch,
        StLock
    } state_e;

    // Larger minus smaller, so the difference never wraps.
    function automatic logic [CntWidth-1:0] abs_diff(input logic [CntWidth-1:0] a,
                                                     input logic [CntWidth-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/note_meter.sv
// Measures the half-period of a square-wave tone in clock cycles, reporting it in
// the same code as the tone generator's freq input, with lock and silence flags.
module note_meter
    import note_pkg::*;
#(
    parameter logic [CntWidth-1:0] TIMEOUT  = DefTimeout,
    parameter logic [CntWidth-1:0] TOL      = DefTol,
    parameter logic [CntWidth-1:0] MIN_HALF = DefMinHalf
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                sig_in_i,
    output logic [CntWidth-1:0] freq_out_o,
    output logic                valid_o,
    output logic                locked_o,
    output logic                silent_o
);

    state_e state_q, state_d;

    logic                sig_sync;
    logic                sig_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] prev_q, prev_d;
    logic [CntWidth-1:0] freq_q, freq_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic                silent_q, silent_d;

    logic tone_edge;
    logic timeout;
    logic match_prev;
    logic match_freq;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sig_in_i),
        .q_o   (sig_sync)
    );

    assign tone_edge  = sig_sync ^ sig_q;
    assign timeout    = (cnt_q == TIMEOUT);
    // The sample is the count just before it clears on this edge.
    assign match_prev = (cnt_q >= MIN_HALF) && (abs_diff(cnt_q, prev_q) <= TOL);
    assign match_freq = (cnt_q >= MIN_HALF) && (abs_diff(cnt_q, freq_q) <= TOL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:     state_d = StWaitEdge;
                StWaitEdge: if (tone_edge) state_d = StFirst;
                StFirst: begin
                    if (tone_edge)    state_d = StMatch;
                    else if (timeout) state_d = StWaitEdge;
                end
                StMatch: begin
                    if (tone_edge && match_prev) state_d = StLock;
                    else if (!tone_edge && timeout) state_d = StWaitEdge;
                end
                StLock: begin
                    if (tone_edge && !match_freq) state_d = StMatch;
                    else if (!tone_edge && timeout) state_d = StWaitEdge;
                end
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d    = tone_edge ? '0 : (timeout ? cnt_q : cnt_q + 32'd1);
        prev_d   = prev_q;
        freq_d   = freq_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        silent_d = silent_q;
        if (!enable_i) begin
            cnt_d    = '0;
            prev_d   = '0;
            freq_d   = '0;
            locked_d = 1'b0;
            silent_d = 1'b0;
        end else if (state_q == StIdle) begin
            cnt_d    = '0;
            freq_d   = '0;
            locked_d = 1'b0;
            silent_d = 1'b1;
        end else if (!tone_edge && timeout) begin
            freq_d   = '0;
            locked_d = 1'b0;
            silent_d = 1'b1;
        end else if (tone_edge) begin
            case (state_q)
                StFirst: prev_d = cnt_q;
                StMatch: begin
                    if (match_prev) begin
                        freq_d   = cnt_q;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                        silent_d = 1'b0;
                    end else begin
                        prev_d = cnt_q;
                    end
                end
                StLock: begin
                    if (match_freq) begin
                        freq_d  = cnt_q;
                        valid_d = 1'b1;
                    end else begin
                        locked_d = 1'b0;
                        prev_d   = cnt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q    <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= '0;
            freq_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            silent_q <= 1'b0;
        end else begin
            sig_q    <= sig_sync;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            silent_q <= silent_d;
        end
    end

    assign freq_out_o = freq_q;
    assign valid_o    = valid_q;
    assign locked_o   = locked_q;
    assign silent_o   = silent_q;

endmodule

// File: tb/tb_note_meter.sv
// Directed bench for note_meter: lock, tracking, step, timeout, disable/reset
// and glitch recovery, with hand-computed expected outputs.
module tb_note_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sig_in;
    logic [31:0] freq_out;
    logic        valid;
    logic        locked;
    logic        silent;
    logic        valid_prev;

    int n_checks = 0;
    int n_fail   = 0;

    note_meter #(
        .TIMEOUT  (32'd1000),
        .TOL      (32'd2),
        .MIN_HALF (32'd2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable),
        .sig_in_i   (sig_in),
        .freq_out_o (freq_out),
        .valid_o    (valid),
        .locked_o   (locked),
        .silent_o   (silent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [31:0] ef,
                             input logic el, input logic es);
        check({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
        check({tag, "_freq"}, freq_out, ef);
        check({tag, "_locked"}, {31'd0, locked}, {31'd0, el});
        check({tag, "_silent"}, {31'd0, silent}, {31'd0, es});
    endtask

    // Toggle sig_in 'half' cycles after the previous toggle, then check the
    // outputs three cycles later, when the edge's result is registered.
    task automatic edge_step(input int half, input string tag, input logic ev,
                             input logic [31:0] ef, input logic el, input logic es);
        repeat (half - 3) @(negedge clk);
        sig_in = ~sig_in;
        repeat (3) @(negedge clk);
        check_out(tag, ev, ef, el, es);
    endtask

    // valid must never stay high for two consecutive cycles.
    always @(negedge clk) begin
        if (reset) begin
            valid_prev <= 1'b0;
        end else begin
            n_checks++;
            assert (!(valid && valid_prev)) else begin
                n_fail++;
                $error("FAIL valid_double: observed 1 expected 0");
            end
            valid_prev <= valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_out("disabled_idle", 1'b0, 32'd0, 1'b0, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check_out("enable_silent", 1'b0, 32'd0, 1'b0, 1'b1);

        // Half-period 10: third edge reports code 9.
        edge_step(10, "lock_e1", 1'b0, 32'd0, 1'b0, 1'b1);
        edge_step(10, "lock_e2", 1'b0, 32'd0, 1'b0, 1'b1);
        edge_step(10, "lock_e3", 1'b1, 32'd9, 1'b1, 1'b0);

        // Jitter within tolerance keeps lock and tracks every edge.
        edge_step(9,  "jit_a", 1'b1, 32'd8,  1'b1, 1'b0);
        edge_step(10, "jit_b", 1'b1, 32'd9,  1'b1, 1'b0);
        edge_step(11, "jit_c", 1'b1, 32'd10, 1'b1, 1'b0);
        edge_step(9,  "jit_d", 1'b1, 32'd8,  1'b1, 1'b0);
        edge_step(10, "jit_e", 1'b1, 32'd9,  1'b1, 1'b0);
        edge_step(11, "jit_f", 1'b1, 32'd10, 1'b1, 1'b0);

        // Step to half-period 50.
        edge_step(50, "step_long",   1'b0, 32'd10, 1'b0, 1'b0);
        edge_step(50, "step_relock", 1'b1, 32'd49, 1'b1, 1'b0);

        // Silence: count hits 1000 one cycle before the outputs react.
        repeat (1000) @(negedge clk);
        check_out("pre_timeout", 1'b0, 32'd49, 1'b1, 1'b0);
        @(negedge clk);
        check_out("timeout", 1'b0, 32'd0, 1'b0, 1'b1);

        // Relock at half-period 20, then disable and reset mid-lock.
        edge_step(20, "re_e1", 1'b0, 32'd0,  1'b0, 1'b1);
        edge_step(20, "re_e2", 1'b0, 32'd0,  1'b0, 1'b1);
        edge_step(20, "re_e3", 1'b1, 32'd19, 1'b1, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        check_out("disable", 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_out("reset_mid", 1'b0, 32'd0, 1'b0, 1'b0);
        sig_in = 1'b0;
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check_out("reenable", 1'b0, 32'd0, 1'b0, 1'b1);
        edge_step(20, "post_e1", 1'b0, 32'd0,  1'b0, 1'b1);
        edge_step(20, "post_e2", 1'b0, 32'd0,  1'b0, 1'b1);
        edge_step(20, "post_e3", 1'b1, 32'd19, 1'b1, 1'b0);

        // Tone generator with freq=100 toggles every 101 cycles.
        edge_step(101, "tone_unlock", 1'b0, 32'd19,  1'b0, 1'b0);
        edge_step(101, "tone_lock",   1'b1, 32'd100, 1'b1, 1'b0);

        // One-cycle glitch right after a real edge.
        repeat (98) @(negedge clk);
        sig_in = ~sig_in;
        @(negedge clk);
        sig_in = ~sig_in;
        @(negedge clk);
        sig_in = ~sig_in;
        @(negedge clk);
        check_out("tone_pre_glitch", 1'b1, 32'd100, 1'b1, 1'b0);
        @(negedge clk);
        check_out("glitch_drop", 1'b0, 32'd100, 1'b0, 1'b0);
        repeat (97) @(negedge clk);
        sig_in = ~sig_in;
        repeat (3) @(negedge clk);
        check_out("glitch_recover", 1'b0, 32'd100, 1'b0, 1'b0);
        edge_step(101, "glitch_relock", 1'b1, 32'd100, 1'b1, 1'b0);

        // Difference of exactly TOL+1 breaks lock.
        edge_step(104, "tol_break",  1'b0, 32'd100, 1'b0, 1'b0);
        edge_step(104, "tol_relock", 1'b1, 32'd103, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
